// File: rtl/midi_pkg.sv
// Shared constants and types for the MIDI voice receiver.
package midi_pkg;

    localparam logic [3:0]  STATUS_NOTE_ON    = 4'h9;
    localparam logic [3:0]  STATUS_NOTE_OFF   = 4'h8;
    localparam logic [7:0]  REALTIME_MIN      = 8'hF8;
    localparam int unsigned DEFAULT_BIT_COUNT = 2080;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;

endpackage

// File: rtl/midi_voices_if.sv
// MIDI line in, voice table out. master = line driver side, slave = receiver.
interface midi_voices_if #(
    parameter int unsigned VOICES = 4
);

    logic                  serial;
    logic                  ready;
    logic                  framing_error;
    logic [7*VOICES-1:0]   key_index;
    logic [7*VOICES-1:0]   key_velocity;
    logic [VOICES-1:0]     key_valid;

    modport master (
        output serial,
        input  ready, framing_error, key_index, key_velocity, key_valid
    );

    modport slave (
        input  serial,
        output ready, framing_error, key_index, key_velocity, key_valid
    );

endinterface

// File: rtl/midi_uart_rx.sv
// 8N1 MIDI byte receiver with a 2-flop input synchroniser.
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int unsigned BIT_COUNT = DEFAULT_BIT_COUNT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       serial_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       framing_error_o
);

    localparam int unsigned CntW = $clog2(BIT_COUNT);
    localparam logic [CntW-1:0] BitLast  = CntW'(BIT_COUNT - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(BIT_COUNT / 2 - 1);

    rx_state_e       state_q;
    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            valid_q;
    logic            fe_q;
    logic            rx;

    assign rx              = sync_q[1];
    assign byte_valid_o    = valid_q;
    assign byte_data_o     = shift_q;
    assign framing_error_o = fe_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], serial_i};
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!rx) begin
                        state_q <= StStart;
                        cnt_q   <= '0;
                    end
                end
                StStart: begin
                    // Re-check mid start bit so short glitches are rejected.
                    if (cnt_q == HalfLast) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= rx ? StIdle : StData;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StData: begin
                    if (cnt_q == BitLast) begin
                        cnt_q   <= '0;
                        shift_q <= {rx, shift_q[7:1]};
                        if (bit_q == 3'd7) state_q <= StStop;
                        else               bit_q   <= bit_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StStop: begin
                    if (cnt_q == BitLast) begin
                        state_q <= StIdle;
                        valid_q <= rx;
                        fe_q    <= !rx;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/midi_voices.sv
// Note-on/off parser with running status and an age-ordered table of held keys.
module midi_voices
    import midi_pkg::*;
#(
    parameter int unsigned BIT_COUNT = DEFAULT_BIT_COUNT,
    parameter int unsigned VOICES    = 4,
    parameter int unsigned CHANNEL   = 0,
    parameter bit          OMNI      = 1'b0
) (
    input  logic          clk_i,
    input  logic          reset_i,
    midi_voices_if.slave  bus
);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       rx_fe;

    midi_uart_rx #(
        .BIT_COUNT (BIT_COUNT)
    ) u_rx (
        .clk_i           (clk_i),
        .rst_i           (reset_i),
        .serial_i        (bus.serial),
        .byte_valid_o    (byte_valid),
        .byte_data_o     (byte_data),
        .framing_error_o (rx_fe)
    );

    logic       running_q, running_d;
    logic       note_on_q, note_on_d;
    logic       second_q, second_d;
    logic [6:0] note_q, note_d;
    logic       exec;

    always_comb begin
        running_d = running_q;
        note_on_d = note_on_q;
        second_d  = second_q;
        note_d    = note_q;
        exec      = 1'b0;
        if (rx_fe) begin
            running_d = 1'b0;
            second_d  = 1'b0;
        end else if (byte_valid) begin
            if (byte_data >= REALTIME_MIN) begin
                // Realtime bytes leave the parser untouched, even mid-pair.
            end else if (byte_data[7:4] == 4'hF) begin
                running_d = 1'b0;
            end else if (byte_data[7]) begin
                second_d  = 1'b0;
                note_on_d = (byte_data[7:4] == STATUS_NOTE_ON);
                running_d = (byte_data[7:4] == STATUS_NOTE_ON ||
                             byte_data[7:4] == STATUS_NOTE_OFF) &&
                            (OMNI || byte_data[3:0] == 4'(CHANNEL));
            end else if (running_q) begin
                if (!second_q) begin
                    note_d   = byte_data[6:0];
                    second_d = 1'b1;
                end else begin
                    exec     = 1'b1;
                    second_d = 1'b0;
                end
            end
        end
    end

    logic [6:0]        idx_q [VOICES];
    logic [6:0]        idx_d [VOICES];
    logic [6:0]        vel_q [VOICES];
    logic [6:0]        vel_d [VOICES];
    logic [VOICES-1:0] valid_q, valid_d;
    logic              ready_q, ready_d;
    logic              match_found, free_found, is_on;
    int                match_idx, free_idx;
    logic [6:0]        vel_in;

    always_comb begin
        idx_d       = idx_q;
        vel_d       = vel_q;
        valid_d     = valid_q;
        ready_d     = 1'b0;
        match_found = 1'b0;
        match_idx   = 0;
        free_found  = 1'b0;
        free_idx    = 0;
        vel_in      = byte_data[6:0];
        is_on       = note_on_q && (vel_in != 7'd0);
        for (int i = 0; i < VOICES; i++) begin
            if (!match_found && valid_q[i] && idx_q[i] == note_q) begin
                match_found = 1'b1;
                match_idx   = i;
            end
            if (!free_found && !valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = i;
            end
        end
        if (exec && is_on) begin
            ready_d = 1'b1;
            for (int i = 0; i < VOICES; i++) begin
                if (match_found) begin
                    if (i == match_idx) vel_d[i] = vel_in;
                end else if (free_found) begin
                    if (i == free_idx) begin
                        idx_d[i]   = note_q;
                        vel_d[i]   = vel_in;
                        valid_d[i] = 1'b1;
                    end
                end else if (i < VOICES - 1) begin
                    idx_d[i] = idx_q[i+1];
                    vel_d[i] = vel_q[i+1];
                end else begin
                    idx_d[i] = note_q;
                    vel_d[i] = vel_in;
                end
            end
        end else if (exec && match_found) begin
            ready_d = 1'b1;
            for (int i = 0; i < VOICES - 1; i++) begin
                if (i >= match_idx) begin
                    idx_d[i]   = idx_q[i+1];
                    vel_d[i]   = vel_q[i+1];
                    valid_d[i] = valid_q[i+1];
                end
            end
            idx_d[VOICES-1]   = '0;
            vel_d[VOICES-1]   = '0;
            valid_d[VOICES-1] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            running_q <= 1'b0;
            note_on_q <= 1'b0;
            second_q  <= 1'b0;
            note_q    <= '0;
            valid_q   <= '0;
            ready_q   <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                idx_q[i] <= '0;
                vel_q[i] <= '0;
            end
        end else begin
            running_q <= running_d;
            note_on_q <= note_on_d;
            second_q  <= second_d;
            note_q    <= note_d;
            valid_q   <= valid_d;
            ready_q   <= ready_d;
            idx_q     <= idx_d;
            vel_q     <= vel_d;
        end
    end

    for (genvar g = 0; g < VOICES; g++) begin : g_pack
        assign bus.key_index[7*g +: 7]    = idx_q[g];
        assign bus.key_velocity[7*g +: 7] = vel_q[g];
    end

    assign bus.key_valid     = valid_q;
    assign bus.ready         = ready_q;
    assign bus.framing_error = rx_fe;

endmodule

// File: tb/tb_midi_voices.sv
// Bench for midi_voices: serial MIDI stimulus, expected tables queued per ready pulse.
module tb_midi_voices;

    localparam int BitCount = 16;
    localparam int Voices   = 4;

    typedef struct packed {
        logic [3:0]  valid;
        logic [27:0] index;
        logic [27:0] vel;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   fe_cnt = 0;

    always #5 clk = ~clk;

    midi_voices_if #(.VOICES(Voices)) bus ();

    midi_voices #(
        .BIT_COUNT (BitCount),
        .VOICES    (Voices),
        .CHANNEL   (0),
        .OMNI      (1'b0)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    function automatic exp_t mk(input logic [3:0] v, input int n0, input int n1, input int n2,
                                input int n3, input int v0, input int v1, input int v2,
                                input int v3);
        exp_t e;
        e.valid = v;
        e.index = {7'(n3), 7'(n2), 7'(n1), 7'(n0)};
        e.vel   = {7'(v3), 7'(v2), 7'(v1), 7'(v0)};
        return e;
    endfunction

    // One clock; outputs observed 1 time unit after the rising edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (bus.framing_error === 1'b1) fe_cnt++;
        if (bus.ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ready: got ready=1 at %0t, required no table change",
                         $time);
            end else begin
                e = sb.pop_front();
                if (bus.key_valid !== e.valid) begin
                    errors++;
                    $display("FAIL key_valid: got %b, required %b", bus.key_valid, e.valid);
                end
                checks++;
                if (bus.key_index !== e.index) begin
                    errors++;
                    $display("FAIL key_index: got %h, required %h", bus.key_index, e.index);
                end
                checks++;
                if (bus.key_velocity !== e.vel) begin
                    errors++;
                    $display("FAIL key_velocity: got %h, required %h", bus.key_velocity, e.vel);
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        bus.serial = 1'b0;
        repeat (BitCount) tick();
        for (int i = 0; i < 8; i++) begin
            bus.serial = b[i];
            repeat (BitCount) tick();
        end
        bus.serial = stop;
        repeat (BitCount) tick();
        bus.serial = 1'b1;
    endtask

    task automatic apply_reset();
        rst        = 1'b1;
        bus.serial = 1'b1;
        sb.delete();
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (bus.ready !== 1'b0 || bus.framing_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: got ready=%b fe=%b, required 0 0", bus.ready,
                     bus.framing_error);
        end
        checks++;
        if (bus.key_valid !== 4'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b, required 0000", bus.key_valid);
        end
        checks++;
        if (bus.key_index !== 28'h0 || bus.key_velocity !== 28'h0) begin
            errors++;
            $display("FAIL reset_table: got idx=%h vel=%h, required 0 0", bus.key_index,
                     bus.key_velocity);
        end
    endtask

    task automatic test_note_on();
        apply_reset();
        sb.push_back(mk(4'b0001, 60, 0, 0, 0, 100, 0, 0, 0));
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        repeat (2 * BitCount) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL note_on_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_running_status();
        apply_reset();
        sb.push_back(mk(4'b0001, 60, 0, 0, 0, 100, 0, 0, 0));
        sb.push_back(mk(4'b0011, 60, 64, 0, 0, 100, 80, 0, 0));
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        send_byte(8'h40); send_byte(8'h50);
        repeat (2 * BitCount) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL running_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_steal();
        apply_reset();
        sb.push_back(mk(4'b0001, 60, 0, 0, 0, 100, 0, 0, 0));
        sb.push_back(mk(4'b0011, 60, 62, 0, 0, 100, 100, 0, 0));
        sb.push_back(mk(4'b0111, 60, 62, 64, 0, 100, 100, 100, 0));
        sb.push_back(mk(4'b1111, 60, 62, 64, 65, 100, 100, 100, 100));
        sb.push_back(mk(4'b1111, 62, 64, 65, 67, 100, 100, 100, 100));
        sb.push_back(mk(4'b1111, 62, 64, 65, 67, 100, 32, 100, 100));
        send_byte(8'h90);
        send_byte(8'h3C); send_byte(8'h64);
        send_byte(8'h3E); send_byte(8'h64);
        send_byte(8'h40); send_byte(8'h64);
        send_byte(8'h41); send_byte(8'h64);
        send_byte(8'h43); send_byte(8'h64);
        send_byte(8'h40); send_byte(8'h20);
        // Note-off for an unheld key: no ready expected.
        send_byte(8'h80); send_byte(8'h30); send_byte(8'h00);
        repeat (2 * BitCount) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL steal_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_note_off();
        apply_reset();
        sb.push_back(mk(4'b0001, 60, 0, 0, 0, 100, 0, 0, 0));
        sb.push_back(mk(4'b0011, 60, 62, 0, 0, 100, 100, 0, 0));
        sb.push_back(mk(4'b0111, 60, 62, 64, 0, 100, 100, 100, 0));
        sb.push_back(mk(4'b0011, 60, 64, 0, 0, 100, 100, 0, 0));
        sb.push_back(mk(4'b0001, 60, 0, 0, 0, 100, 0, 0, 0));
        send_byte(8'h90);
        send_byte(8'h3C); send_byte(8'h64);
        send_byte(8'h3E); send_byte(8'h64);
        send_byte(8'h40); send_byte(8'h64);
        send_byte(8'h80); send_byte(8'h3E); send_byte(8'h00);
        send_byte(8'h90); send_byte(8'h40); send_byte(8'h00);
        repeat (2 * BitCount) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL note_off_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_channel_realtime();
        apply_reset();
        send_byte(8'h91); send_byte(8'h3C); send_byte(8'h64);
        sb.push_back(mk(4'b0001, 60, 0, 0, 0, 100, 0, 0, 0));
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'hF8); send_byte(8'h64);
        repeat (2 * BitCount) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL realtime_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_framing_and_reset();
        apply_reset();
        fe_cnt = 0;
        sb.push_back(mk(4'b0001, 60, 0, 0, 0, 100, 0, 0, 0));
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        send_byte(8'h90, 1'b0);
        repeat (2 * BitCount) tick();
        checks++;
        if (fe_cnt != 1) begin
            errors++;
            $display("FAIL framing_error_pulses: got %0d, required 1", fe_cnt);
        end
        // Running status is gone, so this would-be velocity update is dropped.
        send_byte(8'h3C); send_byte(8'h64);
        repeat (2 * BitCount) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL framing_drain: got %0d pending, required 0", sb.size());
        end
        checks++;
        if (bus.key_valid !== 4'b0001) begin
            errors++;
            $display("FAIL pre_reset_valid: got %b, required 0001", bus.key_valid);
        end
        bus.serial = 1'b0;
        repeat (3 * BitCount) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.key_valid !== 4'b0 || bus.key_index !== 28'h0 || bus.key_velocity !== 28'h0 ||
            bus.ready !== 1'b0 || bus.framing_error !== 1'b0) begin
            errors++;
            $display("FAIL mid_byte_reset: got valid=%b idx=%h vel=%h rdy=%b fe=%b, required 0",
                     bus.key_valid, bus.key_index, bus.key_velocity, bus.ready,
                     bus.framing_error);
        end
        bus.serial = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (12 * BitCount) tick();
        checks++;
        if (bus.key_valid !== 4'b0) begin
            errors++;
            $display("FAIL post_reset_valid: got %b, required 0000", bus.key_valid);
        end
    endtask

    initial begin
        bus.serial = 1'b1;
        test_reset();
        test_note_on();
        test_running_status();
        test_steal();
        test_note_off();
        test_channel_realtime();
        test_framing_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/midi_voices.md
# midi_voices

Polyphonic MIDI receiver. Deserialises the 31.25 kbaud MIDI stream and parses note-on and note-off messages, including running status. Maintains a table of up to VOICES held keys, each with its velocity. Sits between the MIDI opto-input pin and the synth voice generators, and generalises the two-key receiver to N voices, channel filtering and velocity.

## Interface
- BIT_COUNT, 2080, clocks per MIDI bit (65 MHz / 31.25 kHz); must be ≥ 8
- VOICES, 4, number of voice slots; 1–16
- CHANNEL, 0, MIDI channel accepted (0–15)
- OMNI, 0, 1 = accept all channels, ignore CHANNEL
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- serial  input  1  raw MIDI line, idle high, asynchronous to clk
- ready  output  1  one-cycle pulse: voice table changed this cycle
- key_index  output  7*VOICES  note number per slot; slot i = bits [7i+6:7i]
- key_velocity  output  7*VOICES  velocity per slot, same packing
- key_valid  output  VOICES  slot held flags; always packed from bit 0 (thermometer)
- framing_error  output  1  one-cycle pulse: stop bit sampled low

## Operation
- serial passes through a 2-flop synchroniser; all sampling uses the synchronised signal.
- Receiver FSM:
  - IDLE: wait for a low level.
  - START: count BIT_COUNT/2. If the line is still low, go to DATA. If high, it was a glitch; return to IDLE.
  - DATA: sample every BIT_COUNT cycles. Data is LSB first, 8 bits.
  - STOP: sample after BIT_COUNT cycles. High gives byte_valid. Low gives a framing_error pulse, drops the byte and clears running status. Return to IDLE.
- Parser acts on each byte_valid:
  - 0x80–0xEF status: if the high nibble is 8 or 9 and the channel matches (or OMNI=1), latch the running status and expect a note byte. Any other status clears running status; data is then ignored until the next status byte.
  - 0xF0–0xF7: clears running status.
  - 0xF8–0xFF (realtime): ignored, with no effect on parser state. This also applies between data bytes.
  - Data byte (bit7 = 0), no running status: ignored.
  - Data byte, first of pair: latch the note. Second of pair: latch the velocity and execute. The next data byte starts a new pair under the same running status.
- Execute. Note-on with velocity 0 is treated as note-off.
  - Note-on, note already in a valid slot: update that slot's velocity; pulse ready.
  - Note-on, free slot exists: write to the lowest invalid slot; pulse ready.
  - Note-on, table full: steal the oldest. Slots 1..V-1 shift down one, and the new note goes to slot VOICES-1; pulse ready.
  - Note-off, matching slot k: remove it. Slots k+1..V-1 shift down, and the vacated top slot is cleared to index 0, velocity 0, invalid; pulse ready.
  - Note-off, no match: no change, no ready.
- Slot order is age order: slot 0 is the oldest.

## Timing
- Reset values: ready=0, framing_error=0, key_valid=0, all key_index=0 and key_velocity=0, receiver IDLE, running status cleared, pair position = first.
- Reset asserted mid-byte or mid-message discards everything in progress.
- byte_valid occurs on the STOP sample cycle. The table update and ready happen on the next clk edge and are visible together. ready is high exactly one cycle.
- Pin-to-table latency ≈ 2 (synchroniser) + BIT_COUNT/2 + 9·BIT_COUNT + 1 cycles from the falling start edge of the velocity byte.
- At most one execute per byte, so there are never simultaneous table operations.
- Back-to-back bytes with no idle gap must be received. The receiver returns to IDLE within the stop bit.

## Structure
- Package midi_pkg holds:
  - STATUS_NOTE_ON = 4'h9 and STATUS_NOTE_OFF = 4'h8
  - REALTIME_MIN = 8'hF8
  - the receiver state enum (IDLE, START, DATA, STOP)
  - the default BIT_COUNT
- Sub-module midi_uart_rx contains the synchroniser and receiver FSM. Its outputs are byte_valid, byte_data[7:0] and framing_error.
- Parser and voice table live in midi_voices.

## Test plan
Run with BIT_COUNT=16, VOICES=4 and CHANNEL=0.
- 0x90 0x3C 0x64 → one ready; slot0 = 60/100; key_valid=0001.
- 0x90 0x3C 0x64 0x40 0x50 (running status) → slots 60/100 and 64/80; key_valid=0011; two ready pulses.
- Hold 60, 62, 64, 65, then note-on 67 → slots 62, 64, 65, 67; key_valid=1111.
- Holding 60, 62, 64, send 0x80 0x3E 0x00 → slots 60, 64; key_valid=0011. Then 0x90 0x40 0x00 → slot0 = 60; key_valid=0001.
- 0x91 0x3C 0x64 with OMNI=0 → no ready. Then 0x90 0x3C 0xF8 0x64 → realtime ignored; slot0 = 60/100.
- Stop bit forced low on 0x90 → one framing_error pulse. A following 0x3C 0x64 is ignored (no ready). Reset asserted mid-byte → all outputs 0.
